// File: rtl/vga_fb_arbiter_if.sv
// Bundle of scan, draw-write, clear-control and RAM-side signals around the frame-buffer arbiter.
// The arbiter connects as master; the surrounding logic (timing block, drawer, RAM) as slave.
interface vga_fb_arbiter_if #(
  parameter int AW = 16
);
  logic [AW-1:0] vga_addr;
  logic          vga_active;
  logic          vga_pixel;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic          wr_ack;
  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_wdata;
  logic          mem_rdata;

  modport master (
    input  vga_addr, vga_active, wr_req, wr_addr, wr_data, clr_start, mem_rdata,
    output vga_pixel, wr_ack, clr_busy, clr_done, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output vga_addr, vga_active, wr_req, wr_addr, wr_data, clr_start, mem_rdata,
    input  vga_pixel, wr_ack, clr_busy, clr_done, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port 1-bit frame-buffer arbiter: scan reads own the visible window, clear sweep then draw writes use blanking.
// RAM side is combinational from the grant; vga_pixel follows vga_addr by two cycles; writes stall (wr_req held) until granted.
module vga_fb_arbiter #(
  parameter int   AW      = 16,
  parameter logic CLR_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  vga_fb_arbiter_if.master  bus
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_clr_cnt;
  logic          r_act_d;
  logic          r_vga_pixel;
  logic          r_clr_done;
  logic          w_grant_clr;
  logic          w_grant_wr;
  logic          w_clr_last;

  assign w_clr_last = (r_clr_cnt == {AW{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.clr_start) w_next = S_CLEAR;
      S_CLEAR: if (w_grant_clr && w_clr_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A clr_start arriving in IDLE pre-empts any pending write, which then waits out the sweep.
  always_comb begin
    w_grant_clr   = (r_state == S_CLEAR) && !bus.vga_active;
    w_grant_wr    = (r_state == S_IDLE) && !bus.clr_start && !bus.vga_active && bus.wr_req;
    bus.mem_addr  = bus.vga_addr;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 1'b0;
    bus.wr_ack    = 1'b0;
    bus.clr_busy  = (r_state == S_CLEAR);
    if (w_grant_clr) begin
      bus.mem_addr  = r_clr_cnt;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = CLR_VAL;
    end else if (w_grant_wr) begin
      bus.mem_addr  = bus.wr_addr;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = bus.wr_data;
      bus.wr_ack    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_cnt   <= '0;
      r_act_d     <= 1'b0;
      r_vga_pixel <= 1'b0;
      r_clr_done  <= 1'b0;
    end else begin
      r_act_d     <= bus.vga_active;
      r_vga_pixel <= bus.mem_rdata & r_act_d;
      r_clr_done  <= w_grant_clr && w_clr_last;
      if (r_state == S_IDLE && bus.clr_start) r_clr_cnt <= '0;
      else if (w_grant_clr)                   r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  assign bus.vga_pixel = r_vga_pixel;
  assign bus.clr_done  = r_clr_done;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter with a behavioural sync RAM and a scoreboard for read-back pixels and writes.
module tb_vga_fb_arbiter;
  localparam int   AW      = 12;
  localparam int   N       = 1 << AW;
  localparam logic CLR_VAL = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.AW(AW)) bus ();
  vga_fb_arbiter #(.AW(AW), .CLR_VAL(CLR_VAL)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic ram [0:N-1];
  logic ram_fill = 1'b0;
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < N; i++) ram[i] <= 1'b1;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int errors = 0;
  int checks = 0;
  logic ref_mem [0:N-1];
  logic exp_q [$];
  logic [AW:0] wq [$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fill_ones();
    ram_fill = 1'b1;
    step();
    ram_fill = 1'b0;
    for (int i = 0; i < N; i++) ref_mem[i] = 1'b1;
  endtask

  task automatic scan(input int start, input int cnt, input bit mixed);
    logic e;
    int we_err = 0;
    exp_q.delete();
    for (int i = 0; i < cnt + 2; i++) begin
      if (i < cnt) begin
        bus.vga_addr   = AW'(start + i);
        bus.vga_active = mixed ? (i % 3 != 2) : 1'b1;
      end else begin
        bus.vga_active = 1'b0;
      end
      exp_q.push_back(bus.vga_active ? ref_mem[bus.vga_addr] : 1'b0);
      @(negedge clk);
      if (bus.vga_active && bus.mem_we) we_err++;
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.vga_pixel !== e) begin
          errors++;
          $display("FAIL scan_pixel i=%0d got=%0b exp=%0b", i, bus.vga_pixel, e);
        end
      end
      step();
    end
    checks++;
    if (we_err !== 0) begin errors++; $display("FAIL scan_no_write got=%0d exp=0", we_err); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.vga_addr = '0; bus.vga_active = 1'b0; bus.wr_req = 1'b0;
    bus.wr_addr = '0; bus.wr_data = 1'b0; bus.clr_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (bus.vga_pixel !== 1'b0) begin errors++; $display("FAIL reset_vga_pixel got=%0b exp=0", bus.vga_pixel); end
    if (bus.wr_ack !== 1'b0)    begin errors++; $display("FAIL reset_wr_ack got=%0b exp=0", bus.wr_ack); end
    if (bus.clr_busy !== 1'b0)  begin errors++; $display("FAIL reset_clr_busy got=%0b exp=0", bus.clr_busy); end
    if (bus.clr_done !== 1'b0)  begin errors++; $display("FAIL reset_clr_done got=%0b exp=0", bus.clr_done); end
    if (bus.mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we got=%0b exp=0", bus.mem_we); end
    if (bus.mem_addr !== '0)    begin errors++; $display("FAIL reset_mem_addr got=%0h exp=0", bus.mem_addr); end
    if (bus.mem_wdata !== 1'b0) begin errors++; $display("FAIL reset_mem_wdata got=%0b exp=0", bus.mem_wdata); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_clear_full();
    int busy_cnt = 0, done_cnt = 0, walk_err = 0, exp_addr = 0;
    fill_ones();
    bus.vga_active = 1'b0;
    for (int c = 0; c < N + 8; c++) begin
      bus.clr_start = (c == 0) || (c == 100);
      @(negedge clk);
      if (bus.clr_busy) busy_cnt++;
      if (bus.clr_done) done_cnt++;
      if (bus.mem_we) begin
        if (bus.mem_addr !== exp_addr[AW-1:0] || bus.mem_wdata !== CLR_VAL) walk_err++;
        exp_addr++;
      end
      step();
    end
    bus.clr_start = 1'b0;
    checks += 4;
    if (busy_cnt !== N)  begin errors++; $display("FAIL clr_busy_len got=%0d exp=%0d", busy_cnt, N); end
    if (done_cnt !== 1)  begin errors++; $display("FAIL clr_done_pulses got=%0d exp=1", done_cnt); end
    if (walk_err !== 0)  begin errors++; $display("FAIL clr_walk got=%0d exp=0", walk_err); end
    if (exp_addr !== N)  begin errors++; $display("FAIL clr_write_count got=%0d exp=%0d", exp_addr, N); end
    for (int i = 0; i < N; i++) ref_mem[i] = CLR_VAL;
    scan(0, N, 1'b0);
  endtask

  task automatic test_write_while_active();
    logic [AW:0] w;
    int hold_err = 0;
    logic [AW:0] pat [4];
    pat[0] = {12'h305, 1'b1}; pat[1] = {12'h306, 1'b0}; pat[2] = {12'h304, 1'b0}; pat[3] = {12'h7ff, 1'b1};
    bus.vga_active = 1'b1; bus.vga_addr = '0;
    bus.wr_req = 1'b1; bus.wr_addr = 12'h810; bus.wr_data = 1'b1;
    wq.push_back({12'h810, 1'b1});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.wr_ack || bus.mem_we) hold_err++;
      step();
    end
    checks++;
    if (hold_err !== 0) begin errors++; $display("FAIL active_blocks_write got=%0d exp=0", hold_err); end
    bus.vga_active = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        bus.wr_addr = pat[k-1][AW:1]; bus.wr_data = pat[k-1][0];
        wq.push_back(pat[k-1]);
      end
      @(negedge clk);
      checks++;
      if (bus.wr_ack !== 1'b1) begin
        errors++; $display("FAIL wr_ack k=%0d got=%0b exp=1", k, bus.wr_ack);
      end else begin
        w = wq.pop_front();
        ref_mem[w[AW:1]] = w[0];
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== w[AW:1] || bus.mem_wdata !== w[0]) begin
          errors++;
          $display("FAIL wr_issue k=%0d got=we%0b a%0h d%0b exp=we1 a%0h d%0b",
                   k, bus.mem_we, bus.mem_addr, bus.mem_wdata, w[AW:1], w[0]);
        end
      end
      step();
    end
    bus.wr_req = 1'b0;
    checks++;
    if (wq.size() !== 0) begin errors++; $display("FAIL wr_queue_left got=%0d exp=0", wq.size()); end
    wq.delete();
  endtask

  task automatic test_read_latency();
    scan(12'h300, 12, 1'b0);
    scan(12'h2fe, 24, 1'b1);
    scan(12'h7fc, 24, 1'b1);
    scan(12'h808, 16, 1'b0);
  endtask

  task automatic test_clear_toggle();
    int busy_cnt = 0, done_cnt = 0, walk_err = 0, exp_addr = 0, act_we = 0;
    for (int c = 0; c < 2 * N + 16; c++) begin
      bus.clr_start  = (c == 0);
      bus.vga_active = c[0];
      bus.vga_addr   = AW'(c);
      @(negedge clk);
      if (bus.clr_busy) busy_cnt++;
      if (bus.clr_done) done_cnt++;
      if (bus.mem_we) begin
        if (bus.vga_active) act_we++;
        if (bus.mem_addr !== exp_addr[AW-1:0]) walk_err++;
        exp_addr++;
      end
      step();
    end
    bus.clr_start = 1'b0; bus.vga_active = 1'b0;
    checks += 5;
    if (busy_cnt < 2 * N - 1 || busy_cnt > 2 * N + 1) begin
      errors++; $display("FAIL tog_busy_len got=%0d exp=%0d+-1", busy_cnt, 2 * N);
    end
    if (done_cnt !== 1) begin errors++; $display("FAIL tog_done_pulses got=%0d exp=1", done_cnt); end
    if (walk_err !== 0) begin errors++; $display("FAIL tog_walk got=%0d exp=0", walk_err); end
    if (exp_addr !== N) begin errors++; $display("FAIL tog_write_count got=%0d exp=%0d", exp_addr, N); end
    if (act_we !== 0)   begin errors++; $display("FAIL tog_write_in_active got=%0d exp=0", act_we); end
    for (int i = 0; i < N; i++) ref_mem[i] = CLR_VAL;
  endtask

  task automatic test_clear_with_write();
    int done_c = -1, ack_c = -1, addr_err = 0;
    fill_ones();
    bus.vga_active = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = 12'h123; bus.wr_data = 1'b1;
    for (int c = 0; c < N + 16; c++) begin
      bus.clr_start = (c == 0);
      if (ack_c >= 0) bus.wr_req = 1'b0;
      @(negedge clk);
      if (bus.clr_done && done_c < 0) done_c = c;
      if (bus.wr_ack && ack_c < 0) begin
        ack_c = c;
        if (bus.mem_addr !== 12'h123 || bus.mem_wdata !== 1'b1 || bus.mem_we !== 1'b1) addr_err++;
      end
      step();
    end
    bus.clr_start = 1'b0; bus.wr_req = 1'b0;
    checks += 3;
    if (done_c < 0) begin errors++; $display("FAIL cw_done got=none exp=pulse"); end
    if (ack_c < done_c || ack_c < 0) begin
      errors++; $display("FAIL cw_ack_order got=ack@%0d exp=at_or_after_done@%0d", ack_c, done_c);
    end
    if (addr_err !== 0) begin errors++; $display("FAIL cw_write_issue got=%0d exp=0", addr_err); end
    for (int i = 0; i < N; i++) ref_mem[i] = CLR_VAL;
    ref_mem[12'h123] = 1'b1;
    scan(0, N, 1'b0);
  endtask

  task automatic test_reset_mid();
    int found = 0, done_cnt = 0;
    bus.vga_active = 1'b0;
    for (int c = 0; c < 2 * N && found == 0; c++) begin
      bus.clr_start = (c == 0);
      @(negedge clk);
      if (bus.mem_we && bus.mem_addr == 12'h400) begin
        found = 1;
        rst = 1'b1;
      end else begin
        step();
      end
    end
    bus.clr_start = 1'b0;
    step();
    @(negedge clk);
    checks += 5;
    if (found !== 1)            begin errors++; $display("FAIL rm_reach_400 got=%0d exp=1", found); end
    if (bus.clr_busy !== 1'b0)  begin errors++; $display("FAIL rm_busy got=%0b exp=0", bus.clr_busy); end
    if (bus.mem_we !== 1'b0)    begin errors++; $display("FAIL rm_we got=%0b exp=0", bus.mem_we); end
    if (bus.vga_pixel !== 1'b0) begin errors++; $display("FAIL rm_pixel got=%0b exp=0", bus.vga_pixel); end
    if (bus.clr_done !== 1'b0)  begin errors++; $display("FAIL rm_done got=%0b exp=0", bus.clr_done); end
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.clr_done || bus.clr_busy) done_cnt++;
      step();
    end
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL rm_quiet got=%0d exp=0", done_cnt); end
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== '0) begin
      errors++; $display("FAIL rm_restart got=we%0b a%0h exp=we1 a0", bus.mem_we, bus.mem_addr);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear_full();
    test_write_while_active();
    test_read_latency();
    test_clear_toggle();
    test_clear_with_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
